// File: rtl/vga_scanout.sv
// VGA timing generator and frame-memory scanout: stage 0 counters, stage 1 read request,
// stage 3 read data, stage 4 registered colour/syncs (4-clock pipeline).
module vga_scanout #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int DATA_SIZE = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        display_en,
    output logic                        rd_en,
    output logic [18:0]                 rd_addr,
    input  logic signed [DATA_SIZE-1:0] rd_data,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        blank_n,
    output logic [7:0]                  red,
    output logic [7:0]                  green,
    output logic [7:0]                  blue,
    output logic                        frame_done
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_BEG     = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_BEG     = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
        logic de;
        logic fd;
    } ctl_t;

    localparam ctl_t CTL_RESET = '{hs: 1'b1, vs: 1'b1, blank: 1'b0, de: 1'b0, fd: 1'b0};

    logic [HW-1:0] h_count;
    logic [VW-1:0] v_count;
    logic [18:0]   pix_cnt;
    logic [18:0]   base_addr;
    logic          active0;
    ctl_t          ctl0, ctl1, ctl2, ctl3;
    logic [7:0]    scaled;
    logic [7:0]    red_c, green_c, blue_c;

    always_ff @(posedge clock) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_count == H_LAST) begin
            h_count <= '0;
            v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
        end else begin
            h_count <= h_count + 1'b1;
        end
    end

    // The pixel counter restarts at the top-left pixel, so the address there is forced to 0.
    always_comb begin
        active0   = (h_count < H_ACT) && (v_count < V_ACT);
        base_addr = (h_count == '0 && v_count == '0) ? '0 : pix_cnt;
        ctl0.hs    = !((h_count >= HS_BEG) && (h_count < HS_END));
        ctl0.vs    = !((v_count >= VS_BEG) && (v_count < VS_END));
        ctl0.blank = active0;
        ctl0.de    = display_en;
        ctl0.fd    = (h_count == H_ACT_LAST) && (v_count == V_ACT_LAST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
            pix_cnt <= '0;
            ctl1    <= CTL_RESET;
            ctl2    <= CTL_RESET;
            ctl3    <= CTL_RESET;
        end else begin
            rd_en   <= active0 && display_en;
            if (active0 && display_en)
                rd_addr <= base_addr;
            pix_cnt <= active0 ? base_addr + 19'd1 : base_addr;
            ctl1    <= ctl0;
            ctl2    <= ctl1;
            ctl3    <= ctl2;
        end
    end

    // Read data returning now belongs to the pixel held in ctl3.
    always_comb begin
        scaled  = {5'd0, rd_data[2:0]} * 8'd36;
        red_c   = '0;
        green_c = '0;
        blue_c  = '0;
        if (ctl3.blank && ctl3.de && !rd_data[DATA_SIZE-1]) begin
            red_c   = scaled;
            green_c = 8'd255 - scaled;
            blue_c  = 8'h80;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            blank_n    <= 1'b0;
            frame_done <= 1'b0;
            red        <= '0;
            green      <= '0;
            blue       <= '0;
        end else begin
            hsync      <= ctl3.hs;
            vsync      <= ctl3.vs;
            blank_n    <= ctl3.blank;
            frame_done <= ctl3.fd;
            red        <= red_c;
            green      <= green_c;
            blue       <= blue_c;
        end
    end

endmodule
